// File: rtl/board_read_arbiter.sv
// board_read_arbiter: arbitrates the seven board-RAM read clients (display priority, round-robin 0..5,
// bounded burst lock) and returns a read-valid strobe aligned to the RAM read data.
module board_read_arbiter #(
    parameter int DATA_W     = 4,
    parameter int RD_LATENCY = 1,
    parameter int MAX_LOCK   = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [6:0]        req,
    input  logic [6:0]        lock,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [2:0]        select,
    output logic [6:0]        grant,
    output logic [6:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;

    state_t      state_q;
    logic [6:0]  grant_q;
    logic [2:0]  sel_q;
    logic [2:0]  rr_q;
    logic [7:0]  cnt_q;
    logic [6:0]  vpipe_q [RD_LATENCY];
    logic [6:0]  mreq;
    logic [3:0]  pick;
    logic [2:0]  win;
    logic        any;
    logic        hold;

    // Returns {hit, index} of the first set bit of r searching upward from p, wrapping 5 -> 0.
    function automatic logic [3:0] rr_pick(input logic [5:0] r, input logic [2:0] p);
        logic [3:0] s;
        rr_pick = 4'd0;
        for (int i = 5; i >= 0; i--) begin
            s = {1'b0, p} + 4'(i);
            s = (s >= 4'd6) ? s - 4'd6 : s;
            rr_pick = r[s[2:0]] ? {1'b1, s[2:0]} : rr_pick;
        end
    endfunction

    always_comb begin
        mreq = req & ~grant_q;
        pick = rr_pick(mreq[5:0], rr_q);
        win  = mreq[6] ? 3'd6 : pick[2:0];
        any  = mreq[6] | pick[3];
        // The lock count already includes the GRANT cycle, so the burst ends after MAX_LOCK grants.
        hold = (|(req & lock & grant_q)) &&
               (state_q == GRANT || (state_q == LOCKED && ({1'b0, cnt_q} + 9'd1) < 9'(MAX_LOCK)));
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= 3'd7;
            rr_q    <= '0;
            cnt_q   <= '0;
        end else if (hold) begin
            state_q <= LOCKED;
            cnt_q   <= (state_q == GRANT) ? 8'd1 : cnt_q + 8'd1;
        end else if (any) begin
            state_q <= GRANT;
            grant_q <= 7'(1) << win;
            sel_q   <= win;
            cnt_q   <= '0;
            if (!mreq[6])
                rr_q <= (win == 3'd5) ? 3'd0 : win + 3'd1;
        end else begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= 3'd7;
            cnt_q   <= '0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < RD_LATENCY; i++)
                vpipe_q[i] <= '0;
        end else begin
            vpipe_q[0] <= grant_q;
            for (int i = 1; i < RD_LATENCY; i++)
                vpipe_q[i] <= vpipe_q[i-1];
        end
    end

    assign select = sel_q;
    assign grant  = grant_q;
    assign busy   = |grant_q;
    assign rvalid = vpipe_q[RD_LATENCY-1];
    assign rdata  = ram_rdata;
endmodule

// File: tb/tb_board_read_arbiter.sv
// tb_board_read_arbiter: scoreboard bench; stimulus queues expected grants/read-valids, monitors pop and compare.
module tb_board_read_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] req = '0, lock = '0, req3 = '0, lock3 = '0;
    logic [3:0] ram_rdata = '0;
    logic [2:0] select, select3;
    logic [6:0] grant, rvalid, grant3, rvalid3;
    logic [3:0] rdata, rdata3;
    logic       busy, busy3;
    int         n_chk = 0, n_fail = 0;
    int         exp_g[$], exp_rv[$], exp_g3[$], exp_rv3[$];

    always #5 clk = ~clk;

    board_read_arbiter #(.DATA_W(4), .RD_LATENCY(1), .MAX_LOCK(16)) dut (
        .Clk(clk), .Reset_n(rst_n), .req(req), .lock(lock), .ram_rdata(ram_rdata),
        .select(select), .grant(grant), .rvalid(rvalid), .rdata(rdata), .busy(busy));

    board_read_arbiter #(.DATA_W(4), .RD_LATENCY(3), .MAX_LOCK(2)) dut3 (
        .Clk(clk), .Reset_n(rst_n), .req(req3), .lock(lock3), .ram_rdata(4'd0),
        .select(select3), .grant(grant3), .rvalid(rvalid3), .rdata(rdata3), .busy(busy3));

    function automatic logic [3:0] tile(input int s);
        return 4'(s * 5 + 3);
    endfunction

    // One-cycle-latency RAM model addressed by the select mux.
    always @(posedge clk) ram_rdata <= tile(int'(select));

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect1(input int c);
        exp_g.push_back(c);
        exp_rv.push_back(c);
    endtask

    task automatic expect3(input int c);
        exp_g3.push_back(c);
        exp_rv3.push_back(c);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (grant != 0) begin
                if (exp_g.size() == 0) chk("unexpected_grant", int'(grant), 0);
                else begin
                    automatic int c = exp_g.pop_front();
                    chk("grant", int'(grant), 1 << c);
                    chk("select", int'(select), c);
                end
            end else chk("idle_select", int'(select), 7);
            if (rvalid != 0) begin
                if (exp_rv.size() == 0) chk("unexpected_rvalid", int'(rvalid), 0);
                else begin
                    automatic int c = exp_rv.pop_front();
                    chk("rvalid", int'(rvalid), 1 << c);
                    chk("rdata", int'(rdata), int'(tile(c)));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (grant3 != 0) begin
                if (exp_g3.size() == 0) chk("unexpected_grant3", int'(grant3), 0);
                else begin
                    automatic int c = exp_g3.pop_front();
                    chk("grant3", int'(grant3), 1 << c);
                    chk("select3", int'(select3), c);
                end
            end else chk("idle_select3", int'(select3), 7);
            if (rvalid3 != 0) begin
                if (exp_rv3.size() == 0) chk("unexpected_rvalid3", int'(rvalid3), 0);
                else begin
                    automatic int c = exp_rv3.pop_front();
                    chk("rvalid3", int'(rvalid3), 1 << c);
                end
            end
        end
    end

    initial begin
        repeat (2) cyc();
        chk("rst_select", int'(select), 7);
        chk("rst_grant", int'(grant), 0);
        chk("rst_rvalid", int'(rvalid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_select3", int'(select3), 7);
        rst_n = 1'b1;
        cyc();
        // single pulse from g2
        expect1(1);
        req = 7'h02;
        cyc();
        req = '0;
        chk("t1_grant", int'(grant), 'h02);
        chk("t1_select", int'(select), 1);
        chk("t1_busy", int'(busy), 1);
        cyc();
        chk("t1_rvalid", int'(rvalid), 'h02);
        chk("t1_rdata", int'(rdata), int'(tile(1)));
        cyc();
        chk("t1_idle_select", int'(select), 7);
        chk("t1_idle_busy", int'(busy), 0);
        repeat (2) cyc();
        // round-robin over clients 0,2,4 starting from rr_ptr=2
        foreach (exp_g[i]) ;
        expect1(2); expect1(4); expect1(0); expect1(2); expect1(4); expect1(0);
        req = 7'h15;
        repeat (6) cyc();
        req = '0;
        repeat (3) cyc();
        // display beats PacMan, then PacMan
        expect1(6); expect1(4);
        req = 7'h50;
        cyc();
        req = 7'h10;
        cyc();
        req = '0;
        repeat (3) cyc();
        // paint locks (wins via rr_ptr=5 over g1), 16-grant burst, g1 once, paint again
        for (int i = 0; i < 16; i++) expect1(5);
        expect1(0); expect1(5); expect1(5); expect1(5);
        req = 7'h21;
        lock = 7'h20;
        repeat (20) cyc();
        req = '0;
        lock = '0;
        repeat (4) cyc();
        // reset while g4 read is in flight
        req = 7'h08;
        cyc();
        req = '0;
        chk("t5_grant", int'(grant), 'h08);
        rst_n = 1'b0;
        #1;
        chk("t5_select", int'(select), 7);
        chk("t5_grant_clr", int'(grant), 0);
        chk("t5_busy", int'(busy), 0);
        cyc();
        chk("t5_rvalid_a", int'(rvalid), 0);
        cyc();
        chk("t5_rvalid_b", int'(rvalid), 0);
        rst_n = 1'b1;
        cyc();
        chk("t5_rvalid_c", int'(rvalid), 0);
        // rr_ptr back at 0 after reset: g1 before paint
        expect1(0); expect1(5);
        req = 7'h21;
        repeat (2) cyc();
        req = '0;
        repeat (4) cyc();
        // RD_LATENCY=3 instance
        expect3(1); expect3(2); expect3(3);
        req3 = 7'h0E;
        cyc();
        chk("t6_grant3", int'(grant3), 'h02);
        repeat (2) cyc();
        req3 = '0;
        cyc();
        chk("t6_rvalid3_c4", int'(rvalid3), 'h02);
        cyc();
        chk("t6_rvalid3_c5", int'(rvalid3), 'h04);
        cyc();
        chk("t6_rvalid3_c6", int'(rvalid3), 'h08);
        cyc();
        chk("t6_rvalid3_c7", int'(rvalid3), 0);
        repeat (2) cyc();
        // MAX_LOCK=2: g1 burst of two, g2 in between, lock from non-granted g1 ignored
        expect3(0); expect3(0); expect3(1); expect3(0); expect3(0); expect3(1);
        req3 = 7'h03;
        lock3 = 7'h01;
        repeat (6) cyc();
        req3 = '0;
        lock3 = '0;
        repeat (6) cyc();
        chk("exp_g_empty", exp_g.size(), 0);
        chk("exp_rv_empty", exp_rv.size(), 0);
        chk("exp_g3_empty", exp_g3.size(), 0);
        chk("exp_rv3_empty", exp_rv3.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
